// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Bridges a datapath's instruction-fetch and data ports onto one single-port
// RAM. One access is in flight at a time and data requests win over fetches.
// An access that sees no ram_ready for MAX_WAIT cycles is aborted. It then
// completes with a poison word (32'hBAD1BAD1) and sets the sticky err flag.
// A halt request is honoured only from IDLE, so an access that is already
// under way always finishes and returns its hit first.
//
// Ports
//   CLK, RST         clock; asynchronous active-high reset
//   imemREN          fetch request, held by the datapath until ihit
//   imemaddr         fetch address
//   imemload, ihit   fetched word and its one-cycle completion pulse
//   dmemREN/dmemWEN  data read / write request, held until dhit
//   dmemaddr         data address
//   dmemstore        data write value
//   dmemload, dhit   read word and its one-cycle completion pulse
//   halt             datapath halt request
//   ramREN/ramWEN    RAM read / write strobes
//   ramaddr          RAM address
//   ramstore         RAM write data
//   ramload          RAM read data, valid when ram_ready is high
//   ram_ready        RAM access completes this cycle
//   flushed          responder is halted and idle
//   err              sticky flag: at least one access timed out
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    input  logic        halt,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        flushed,
    output logic        err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);
    localparam logic [31:0] POISON = 32'hBAD1BAD1;

    typedef enum logic [2:0] {
        IDLE,
        DACC,
        IACC,
        RESP,
        HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      store_q, store_d;
    logic             wr_q, wr_d;        // captured op is a write
    logic             isd_q, isd_d;      // captured access is a data access
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dload_q, dload_d;
    logic [31:0]      iload_q, iload_d;
    logic             err_q, err_d;

    logic             in_acc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            isd_q   <= 1'b0;
            cnt_q   <= '0;
            dload_q <= '0;
            iload_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wr_q    <= wr_d;
            isd_q   <= isd_d;
            cnt_q   <= cnt_d;
            dload_q <= dload_d;
            iload_q <= iload_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        store_d = store_q;
        wr_d    = wr_q;
        isd_d   = isd_q;
        cnt_d   = cnt_q;
        dload_d = dload_q;
        iload_d = iload_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (dmemREN || dmemWEN) begin
                    // A write wins when both strobes are up.
                    state_d = DACC;
                    addr_d  = dmemaddr;
                    store_d = dmemstore;
                    wr_d    = dmemWEN;
                    isd_d   = 1'b1;
                    cnt_d   = '0;
                end else if (imemREN) begin
                    state_d = IACC;
                    addr_d  = imemaddr;
                    store_d = '0;
                    wr_d    = 1'b0;
                    isd_d   = 1'b0;
                    cnt_d   = '0;
                end
            end

            DACC, IACC: begin
                if (ram_ready) begin
                    state_d = RESP;
                    if (isd_q) begin
                        if (!wr_q) begin
                            dload_d = ramload;
                        end
                    end else begin
                        iload_d = ramload;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // This is the MAX_WAIT-th cycle without ram_ready,
                    // so give up and hand back the poison word.
                    if (cnt_q == LAST_WAIT) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        if (isd_q) begin
                            dload_d = POISON;
                        end else begin
                            iload_d = POISON;
                        end
                    end
                end
            end

            // RESP lasts one cycle, so a request the datapath still holds
            // is not picked up a second time.
            RESP: begin
                state_d = IDLE;
            end

            HALTED: begin
                state_d = HALTED;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_acc   = (state_q == DACC) || (state_q == IACC);

    assign ramREN   = in_acc && !wr_q;
    assign ramWEN   = in_acc && wr_q;
    assign ramaddr  = in_acc ? addr_q  : 32'h0;
    assign ramstore = in_acc ? store_q : 32'h0;

    assign dhit     = (state_q == RESP) && isd_q;
    assign ihit     = (state_q == RESP) && !isd_q;
    assign dmemload = dload_q;
    assign imemload = iload_q;
    assign flushed  = (state_q == HALTED);
    assign err      = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: MAX_WAIT, 15, maximum cycles an access waits for ram_ready before it is aborted.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 imemREN  in  1  datapath instruction-fetch request, held until ihit.
REQ-005 imemaddr  in  32  fetch address.
REQ-006 imemload  out  32  fetched instruction, valid when ihit=1.
REQ-007 ihit  out  1  one-cycle fetch-complete pulse.
REQ-008 dmemREN  in  1  datapath data-read request, held until dhit.
REQ-009 dmemWEN  in  1  datapath data-write request, held until dhit.
REQ-010 dmemaddr  in  32  data address.
REQ-011 dmemstore  in  32  write data.
REQ-012 dmemload  out  32  read data, valid when dhit=1.
REQ-013 dhit  out  1  one-cycle data-complete pulse.
REQ-014 halt  in  1  datapath halt request.
REQ-015 ramREN, ramWEN  out  1 each  single-port RAM strobes.
REQ-016 ramaddr, ramstore  out  32 each  RAM address and write data.
REQ-017 ramload  in  32  RAM read data, valid with ram_ready.
REQ-018 ram_ready  in  1  RAM access complete this cycle.
REQ-019 flushed  out  1  responder idle and halted.
REQ-020 err  out  1  sticky: at least one access timed out.

Function
REQ-021 States: IDLE, DACC, IACC, RESP, HALTED.
REQ-022 IDLE: halt=1 -> HALTED; else dmemREN|dmemWEN -> DACC; else imemREN -> IACC; else stay. Data has priority over fetch.
REQ-023 On leaving IDLE for an access, capture address, store data, op (write if dmemWEN=1, even when dmemREN=1), and clear wait counter.
REQ-024 DACC/IACC: ramaddr/ramstore driven from captured registers; ramWEN=1 for captured write, ramREN=1 otherwise; both 0 in all other states.
REQ-025 Wait counter increments each DACC/IACC cycle with ram_ready=0.
REQ-026 ram_ready=1 in DACC/IACC -> RESP next cycle; read data latched into dmemload (DACC read) or imemload (IACC); dmemload unchanged on write.
REQ-027 Counter reaching MAX_WAIT with ram_ready=0 -> RESP next cycle; corresponding load register = 32'hBAD1BAD1; err set.
REQ-028 RESP: dhit=1 (data access) or ihit=1 (fetch) for exactly this one cycle; next state IDLE. The RESP cycle prevents re-servicing a request the datapath still holds.
REQ-029 Minimum latency: request seen in IDLE at cycle N, ram_ready at N+1 -> hit at cycle N+2; next request sampled at N+3.
REQ-030 halt during DACC/IACC/RESP does not abort; HALTED is entered from the next IDLE.
REQ-031 HALTED absorbing until RST; flushed=1; no RAM strobes; requests ignored; hits stay 0.
REQ-032 Request inputs changing during DACC/IACC have no effect (captured values used).
REQ-033 ram_ready in IDLE/RESP/HALTED ignored.

Reset
REQ-034 RST=1 forces immediately: state IDLE, ihit=dhit=0, ram strobes 0, ramaddr=ramstore=0, imemload=dmemload=0, counter 0, err=0, flushed=0.
REQ-035 RST asserted mid-access abandons it; no hit is produced for it after reset release.

Verification
REQ-036 imemREN=1, imemaddr=0x0000_0004, ram_ready=1 next cycle with ramload=0x2001_0005 -> ramREN=1 with ramaddr=0x4 one cycle, ihit=1 with imemload=0x2001_0005 the cycle after.
REQ-037 imemREN=1 and dmemWEN=1 (dmemaddr=0x80, dmemstore=0xDEAD_BEEF) same cycle -> write serviced first (ramWEN=1, ramstore=0xDEADBEEF), dhit, then fetch, ihit.
REQ-038 dmemREN=1, ram_ready held 0 -> after 15 wait cycles dhit=1, dmemload=0xBAD1BAD1, err=1 and stays 1 through later good accesses.
REQ-039 halt=1 asserted mid-DACC, ram_ready after 3 cycles -> dhit delivered, then HALTED, flushed=1, subsequent imemREN produces no ramREN.
REQ-040 RST pulsed during IACC with ram_ready=0 -> all outputs zero immediately; after release, no ihit until a new request completes.
REQ-041 dmemREN and dmemWEN both 1 -> ramWEN=1, ramREN=0, dmemload unchanged at dhit.
